// File: rtl/processor_pkg.sv
// processor_pkg: shared constants, fetch entry type and sizing helper for the fetch path
//   ADDR_SIZE_DEF / WORD_SIZE_DEF : default code address and instruction word widths
//   fetch_entry_t                 : {ip, word} pair as held in the fetch queue
//   count_width()                 : bits needed to count 0..depth entries
package processor_pkg;
   localparam int ADDR_SIZE_DEF = 18;
   localparam int WORD_SIZE_DEF = 18;
   typedef struct packed {
      logic [ADDR_SIZE_DEF-1:0] ip;
      logic [WORD_SIZE_DEF-1:0] word;
   } fetch_entry_t;
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/processor_fetch_queue_if.sv
// processor_fetch_queue_if: program-memory, redirect/stall and delivery signals of the fetch queue
//   master : the fetch queue (drives code_addr, out_valid, out_word, out_ip, out_ip_plus_one, queue_count)
//   slave  : the surrounding core/memory (drives code_word, redirect, redirect_ip, stall, out_ready)
interface processor_fetch_queue_if
   import processor_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int CW        = 3
);
   logic [ADDR_SIZE-1:0] code_addr;
   logic [WORD_SIZE-1:0] code_word;
   logic                 redirect;
   logic [ADDR_SIZE-1:0] redirect_ip;
   logic                 stall;
   logic                 out_valid;
   logic                 out_ready;
   logic [WORD_SIZE-1:0] out_word;
   logic [ADDR_SIZE-1:0] out_ip;
   logic [ADDR_SIZE-1:0] out_ip_plus_one;
   logic [CW-1:0]        queue_count;
   modport master (
      output code_addr, out_valid, out_word, out_ip, out_ip_plus_one, queue_count,
      input  code_word, redirect, redirect_ip, stall, out_ready
   );
   modport slave (
      input  code_addr, out_valid, out_word, out_ip, out_ip_plus_one, queue_count,
      output code_word, redirect, redirect_ip, stall, out_ready
   );
endinterface

// File: rtl/processor_fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO with push, pop, single-cycle flush and occupancy count
//   clock_i : clock
//   flush_i : empties the FIFO at the next edge, overriding push/pop
//   push_i  : write data_i (caller never pushes when full)
//   pop_i   : drop the head entry (caller never pops when empty)
//   data_o  : head entry, count_o : number of valid entries
module fetch_fifo
   import processor_pkg::*;
#(
   parameter int W     = 36,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = count_width(DEPTH)
) (
   input  logic          clock_i,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  data_i,
   output logic [W-1:0]  data_o,
   output logic [CW-1:0] count_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q;
   always_ff @(posedge clock_i) begin
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
   end
   always_ff @(posedge clock_i) begin
      if (flush_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i) rd_q <= rd_q + AW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end
   assign data_o  = mem_q[rd_q];
   assign count_o = count_q;
endmodule

// File: rtl/processor_fetch_queue.sv
// processor_fetch_queue: instruction prefetch queue between program memory and the decoder
//   clock, reset : clock and synchronous active-high reset
//   bus (master) : code_addr/code_word memory port (one-cycle read latency), redirect/redirect_ip,
//                  stall, out_valid/out_ready delivery of {out_word, out_ip, out_ip_plus_one}, queue_count
//   Optional PROCESSOR_FETCH_QUEUE_DEBUG_EN adds debug_hold (freezes issue and pop) and
//   debug_fetch_ip (current fetch address).
module processor_fetch_queue
   import processor_pkg::*;
#(
   parameter int                   ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int                   WORD_SIZE = WORD_SIZE_DEF,
   parameter int                   DEPTH     = 4,
   parameter logic [ADDR_SIZE-1:0] RESET_IP  = '0
) (
   input logic clock,
   input logic reset,
   processor_fetch_queue_if.master bus
`ifdef PROCESSOR_FETCH_QUEUE_DEBUG_EN
   ,
   input  logic                 debug_hold,
   output logic [ADDR_SIZE-1:0] debug_fetch_ip
`endif
);
   localparam int CW = count_width(DEPTH);
   logic [ADDR_SIZE-1:0]           fetch_ip_q, fetch_ip_d, inflight_ip_q, inflight_ip_d;
   logic                           inflight_q, inflight_d;
   logic                           issue, push, pop, flush, hold;
   logic [CW-1:0]                  count;
   logic [CW:0]                    occupancy;
   logic [ADDR_SIZE+WORD_SIZE-1:0] head;
`ifdef PROCESSOR_FETCH_QUEUE_DEBUG_EN
   assign hold           = debug_hold;
   assign debug_fetch_ip = fetch_ip_q;
`else
   assign hold = 1'b0;
`endif
   // The word in flight already owns a slot, so a push can never find the queue full.
   assign occupancy = {1'b0, count} + (CW+1)'(inflight_q);
   assign issue     = !reset && !bus.redirect && !hold && occupancy < (CW+1)'(DEPTH);
   assign flush     = reset || bus.redirect;
   assign push      = inflight_q && !flush;
   assign bus.out_valid = count != '0 && !bus.stall && !flush;
   assign pop       = bus.out_valid && bus.out_ready && !hold;
   assign bus.code_addr       = reset ? RESET_IP : fetch_ip_q;
   assign bus.out_ip          = head[ADDR_SIZE+WORD_SIZE-1:WORD_SIZE];
   assign bus.out_word        = head[WORD_SIZE-1:0];
   assign bus.out_ip_plus_one = bus.out_ip + ADDR_SIZE'(1);
   assign bus.queue_count     = count;
   always_comb begin
      fetch_ip_d    = bus.redirect ? bus.redirect_ip : issue ? fetch_ip_q + ADDR_SIZE'(1) : fetch_ip_q;
      inflight_d    = issue;
      inflight_ip_d = fetch_ip_q;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_ip_q    <= RESET_IP;
         inflight_q    <= 1'b0;
         inflight_ip_q <= '0;
      end else begin
         fetch_ip_q    <= fetch_ip_d;
         inflight_q    <= inflight_d;
         inflight_ip_q <= inflight_ip_d;
      end
   end
   fetch_fifo #(.W(ADDR_SIZE + WORD_SIZE), .DEPTH(DEPTH)) u_fifo (
      .clock_i (clock),
      .flush_i (flush),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({inflight_ip_q, bus.code_word}),
      .data_o  (head),
      .count_o (count)
   );
endmodule

// File: tb/tb_processor_fetch_queue.sv
// tb_processor_fetch_queue: directed vector table, hand sequences and random stimulus against a queue-based model
module tb_processor_fetch_queue;
   import processor_pkg::*;
   localparam int         AS    = 18;
   localparam int         WS    = 18;
   localparam int         DEPTH = 4;
   localparam logic [17:0] RIP  = 18'h100;
   logic clock = 1'b0;
   logic reset = 1'b1;
   processor_fetch_queue_if #(.ADDR_SIZE(AS), .WORD_SIZE(WS), .CW(3)) bus ();
`ifdef PROCESSOR_FETCH_QUEUE_DEBUG_EN
   logic [AS-1:0] dbg_ip;
`endif
   processor_fetch_queue #(.ADDR_SIZE(AS), .WORD_SIZE(WS), .DEPTH(DEPTH), .RESET_IP(RIP)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
`ifdef PROCESSOR_FETCH_QUEUE_DEBUG_EN
      ,
      .debug_hold     (1'b0),
      .debug_fetch_ip (dbg_ip)
`endif
   );
   always #5 clock = ~clock;
   // program memory: word = address ^ 0x3FFFF, one cycle read latency
   always @(posedge clock) bus.code_word <= bus.code_addr ^ 18'h3FFFF;
   fetch_entry_t mq[$];
   bit           m_inf;
   logic [17:0]  m_inf_ip, m_fip;
   int           tests, fails, cyc;
   typedef struct {
      bit r, rd; logic [17:0] rip; bit st, rdy;
      logic [17:0] e_addr; int e_cnt; bit e_v; logic [17:0] e_ip;
   } vec_t;
   vec_t tbl[26];
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask
   task automatic step(input bit r, input bit rd, input logic [17:0] rip, input bit st, input bit rdy);
      bit v, issue;
      @(posedge clock);
      #1;
      reset = r; bus.redirect = rd; bus.redirect_ip = rip; bus.stall = st; bus.out_ready = rdy;
      #1;
      v = mq.size() != 0 && !st && !rd && !r;
      check("code_addr", 32'(bus.code_addr), 32'(r ? RIP : m_fip));
      check("queue_count", 32'(bus.queue_count), 32'(mq.size()));
      check("out_valid", 32'(bus.out_valid), 32'(v));
      if (v) begin
         check("out_ip", 32'(bus.out_ip), 32'(mq[0].ip));
         check("out_word", 32'(bus.out_word), 32'(mq[0].word));
         check("out_ip_plus_one", 32'(bus.out_ip_plus_one), 32'(18'(mq[0].ip + 18'd1)));
      end
      issue = !r && !rd && (mq.size() + int'(m_inf)) < DEPTH;
      if (r || rd) begin
         mq.delete();
         m_inf = 1'b0;
         m_fip = r ? RIP : rip;
      end else begin
         if (v && rdy) void'(mq.pop_front());
         if (m_inf) mq.push_back('{ip: m_inf_ip, word: m_inf_ip ^ 18'h3FFFF});
         m_inf_ip = m_fip;
         m_inf    = issue;
         if (issue) m_fip = m_fip + 18'd1;
      end
      cyc++;
   endtask
   initial begin
      bus.redirect = 1'b0; bus.redirect_ip = '0; bus.stall = 1'b0; bus.out_ready = 1'b1;
      m_inf = 1'b0; m_inf_ip = '0; m_fip = RIP; tests = 0; fails = 0; cyc = 0;
      tbl[0]  = '{1,0,0,0,1, 18'h100,0,0,0};
      tbl[1]  = '{0,0,0,0,1, 18'h100,0,0,0};
      tbl[2]  = '{0,0,0,0,1, 18'h101,0,0,0};
      tbl[3]  = '{0,0,0,0,1, 18'h102,1,1,18'h100};
      tbl[4]  = '{0,0,0,0,1, 18'h103,1,1,18'h101};
      tbl[5]  = '{0,0,0,0,0, 18'h104,1,1,18'h102};
      tbl[6]  = '{0,0,0,0,0, 18'h105,2,1,18'h102};
      tbl[7]  = '{0,0,0,0,0, 18'h106,3,1,18'h102};
      tbl[8]  = '{0,0,0,0,0, 18'h106,4,1,18'h102};
      tbl[9]  = '{0,0,0,0,0, 18'h106,4,1,18'h102};
      tbl[10] = '{0,0,0,0,1, 18'h106,4,1,18'h102};
      tbl[11] = '{0,0,0,0,0, 18'h106,3,1,18'h103};
      tbl[12] = '{0,1,18'h2000,0,1, 18'h107,3,0,0};
      tbl[13] = '{0,0,0,0,1, 18'h2000,0,0,0};
      tbl[14] = '{0,0,0,0,1, 18'h2001,0,0,0};
      tbl[15] = '{0,0,0,0,1, 18'h2002,1,1,18'h2000};
      tbl[16] = '{0,0,0,1,1, 18'h2003,1,0,0};
      tbl[17] = '{0,0,0,1,1, 18'h2004,2,0,0};
      tbl[18] = '{0,0,0,1,1, 18'h2005,3,0,0};
      tbl[19] = '{0,0,0,1,1, 18'h2005,4,0,0};
      tbl[20] = '{0,0,0,0,1, 18'h2005,4,1,18'h2001};
      tbl[21] = '{0,0,0,0,1, 18'h2005,3,1,18'h2002};
      tbl[22] = '{0,0,0,0,1, 18'h2006,2,1,18'h2003};
      tbl[23] = '{0,0,0,0,1, 18'h2007,2,1,18'h2004};
      tbl[24] = '{1,0,0,0,1, 18'h100,2,0,0};
      tbl[25] = '{0,0,0,0,1, 18'h100,0,0,0};
      repeat (2) @(posedge clock);
      for (int i = 0; i < 26; i++) begin
         step(tbl[i].r, tbl[i].rd, tbl[i].rip, tbl[i].st, tbl[i].rdy);
         check("tbl_addr", 32'(bus.code_addr), 32'(tbl[i].e_addr));
         check("tbl_count", 32'(bus.queue_count), 32'(tbl[i].e_cnt));
         check("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].e_v));
         if (tbl[i].e_v) check("tbl_ip", 32'(bus.out_ip), 32'(tbl[i].e_ip));
      end
      // address wrap at the top of the code space
      step(0, 1, 18'h3FFFF, 0, 1);
      step(0, 0, 0, 0, 1);
      check("wrap_addr_hi", 32'(bus.code_addr), 32'h3FFFF);
      step(0, 0, 0, 0, 1);
      check("wrap_addr_lo", 32'(bus.code_addr), 32'h0);
      step(0, 0, 0, 0, 1);
      check("wrap_ip", 32'(bus.out_ip), 32'h3FFFF);
      check("wrap_ip_plus_one", 32'(bus.out_ip_plus_one), 32'h0);
      // reset with the queue full
      repeat (6) step(0, 0, 0, 0, 0);
      check("full_count", 32'(bus.queue_count), 32'd4);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("rst_count", 32'(bus.queue_count), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_addr", 32'(bus.code_addr), 32'(RIP));
      // long stall: nothing delivered, queue fills
      repeat (10) begin
         step(0, 0, 0, 1, 1);
         check("stall_valid", 32'(bus.out_valid), 32'd0);
      end
      check("stall_full", 32'(bus.queue_count), 32'd4);
      repeat (3000)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0 ? 18'h3FFFD : 18'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/processor_fetch_queue.md
PROCESSOR_FETCH_QUEUE -- requirements
Module: processor_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 18: code address width.
REQ-002 SHALL have parameter WORD_SIZE, default 18: instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_IP, default 0: first fetch address after reset.
REQ-005 SHALL have port clock, input, 1, the single clock.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port code_addr, output, ADDR_SIZE, program memory address; the word returns on code_word one cycle later.
REQ-008 SHALL have port code_word, input, WORD_SIZE, program memory read data.
REQ-009 SHALL have port redirect, input, 1, taken branch/call strobe.
REQ-010 SHALL have port redirect_ip, input, ADDR_SIZE, branch target, valid with redirect.
REQ-011 SHALL have port stall, input, 1, global wait; blocks delivery.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the delivery handshake.
REQ-013 SHALL have ports out_word (output, WORD_SIZE), out_ip (output, ADDR_SIZE) and out_ip_plus_one (output, ADDR_SIZE), the head entry.
REQ-014 SHALL have port queue_count, output, clog2(DEPTH)+1, number of valid entries.

Function
REQ-015 SHALL keep fetch_ip, drive code_addr = fetch_ip, and issue a fetch in every cycle where queue_count + inflight < DEPTH, no redirect is present and reset is low.
REQ-016 SHALL, on each issue, set inflight=1 with the issued ip for one cycle and increment fetch_ip modulo 2^ADDR_SIZE; 2^ADDR_SIZE-1 wraps to 0.
REQ-017 SHALL, in the cycle after an issue that is not squashed, push {ip, code_word} into the queue.
REQ-018 SHALL give issue-to-out_valid latency of exactly 2 cycles when the queue is empty and stall is low.
REQ-019 SHALL drive out_valid = (queue_count != 0) AND NOT stall AND NOT redirect.
REQ-020 SHALL pop the head entry when out_valid and out_ready are both high; push and pop in the same cycle leave queue_count unchanged.
REQ-021 SHALL drive out_ip_plus_one = out_ip + 1, wrapped modulo 2^ADDR_SIZE.
REQ-022 SHALL, while stall is high, continue fetching until the queue is full and never pop.
REQ-023 SHALL, on redirect, in the same cycle: flush all entries, squash the inflight word, suppress the pop, issue no fetch, and set fetch_ip <= redirect_ip; code_addr = redirect_ip in the next cycle.
REQ-024 SHALL give redirect priority over stall, push and pop when they occur together.
REQ-025 SHALL never overflow the queue: the inflight word reserves a slot (REQ-015), so a push is never refused.
REQ-026 SHALL leave out_word, out_ip and out_ip_plus_one don't-care while out_valid=0.

Reset
REQ-027 SHALL, in any cycle with reset high, set fetch_ip=RESET_IP, queue_count=0, inflight=0 and out_valid=0, discarding any word in flight.
REQ-028 SHALL drive code_addr=RESET_IP during reset and issue the first fetch in the first cycle with reset low.

Configuration
REQ-029 SHALL use macro PROCESSOR_FETCH_QUEUE_DEBUG_EN.
REQ-030 SHALL, with the macro defined, add input debug_hold (1 bit: freezes issue and pop) and output debug_fetch_ip (ADDR_SIZE: current fetch_ip).
REQ-031 SHALL, without the macro, have neither debug_hold nor debug_fetch_ip and no related logic.

Structure
REQ-032 SHALL take from shared package processor_pkg the default ADDR_SIZE/WORD_SIZE constants and typedef fetch_entry_t {ip, word}.
REQ-033 SHALL implement storage as sub-module fetch_fifo: synchronous FIFO with push, pop, single-cycle flush and count output.

Verification
REQ-034 Reset released, RESET_IP=0x100, out_ready=1, memory returns addr^0x3FFFF -> code_addr 0x100 in cycle 0, out_valid in cycle 2 with out_ip=0x100 and out_ip_plus_one=0x101, then one word per cycle.
REQ-035 out_ready=0, DEPTH=4 -> queue_count reaches 4 and issue stops; code_addr stays at 0x104 until a pop.
REQ-036 redirect with redirect_ip=0x2000 while 3 entries are queued and a fetch is in flight -> queue_count=0 next cycle, code_addr=0x2000, first out_ip=0x2000 two cycles later, and no old word is ever delivered.
REQ-037 stall high for 10 cycles -> out_valid=0 throughout, queue fills to DEPTH; on stall release the words are delivered in order with no gap.
REQ-038 fetch_ip=0x3FFFF -> next issued address 0x0; out_ip_plus_one for 0x3FFFF = 0x0.
REQ-039 reset asserted with the queue full and a fetch in flight -> next cycle queue_count=0, out_valid=0, code_addr=RESET_IP.
